// File: rtl/hwpe_ctrl_package.sv
// Shared types and default sizes for the uloop scheduler and its output FIFO.
package hwpe_ctrl_package;

    localparam int unsigned ULOOP_SCHED_NB_REG     = 4;
    localparam int unsigned ULOOP_SCHED_REG_WIDTH  = 32;
    localparam int unsigned ULOOP_SCHED_NB_LOOPS   = 6;
    localparam int unsigned ULOOP_SCHED_CNT_WIDTH  = 16;
    localparam int unsigned ULOOP_SCHED_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } uloop_sched_state_t;

    typedef struct packed {
        logic [ULOOP_SCHED_NB_REG*ULOOP_SCHED_REG_WIDTH-1:0]   offs;
        logic [ULOOP_SCHED_NB_LOOPS*ULOOP_SCHED_CNT_WIDTH-1:0] idx;
        logic                                                  done;
    } uloop_sched_entry_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_sched_fifo.sv
// Generic show-ahead FIFO; a full FIFO still accepts a push when a pop happens in the same cycle.
module hwpe_ctrl_uloop_sched_fifo
    import hwpe_ctrl_package::*;
#(
    parameter type         entry_t = uloop_sched_entry_t,
    parameter int unsigned DEPTH   = ULOOP_SCHED_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  entry_t                   data_i,
    input  logic                     pop_i,
    output entry_t                   data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    entry_t mem_q [DEPTH];
    ptr_t   wptr_q, rptr_q;
    cnt_t   cnt_q;
    logic   do_push, do_pop;

    assign full_o  = (cnt_q == cnt_t'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + ptr_t'(1);
            if (do_pop)  rptr_q <= rptr_q + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + cnt_t'(1);
                2'b01:   cnt_q <= cnt_q - cnt_t'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the counter alone decides which slots hold valid data.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/hwpe_ctrl_uloop_sched.sv
// Sequences the uloop for one job and buffers its offset/index flags for the streamers.
// Optional stall counter enabled by defining HWPE_ULOOP_SCHED_PERF_EN.
module hwpe_ctrl_uloop_sched
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_REG     = ULOOP_SCHED_NB_REG,
    parameter int unsigned REG_WIDTH  = ULOOP_SCHED_REG_WIDTH,
    parameter int unsigned NB_LOOPS   = ULOOP_SCHED_NB_LOOPS,
    parameter int unsigned CNT_WIDTH  = ULOOP_SCHED_CNT_WIDTH,
    parameter int unsigned FIFO_DEPTH = ULOOP_SCHED_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          evt_done_o,
    output logic                          err_o,
    output logic                          uloop_clear_o,
    output logic                          uloop_enable_o,
    input  logic                          uloop_valid_i,
    input  logic                          uloop_done_i,
    input  logic [NB_REG*REG_WIDTH-1:0]   uloop_offs_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] uloop_idx_i,
    output logic                          offs_valid_o,
    input  logic                          offs_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]   offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] idx_o,
`ifdef HWPE_ULOOP_SCHED_PERF_EN
    input  logic                          perf_clr_i,
    output logic [31:0]                   stall_cnt_o,
`endif
    output logic                          last_o
);

    typedef struct packed {
        logic [NB_REG*REG_WIDTH-1:0]   offs;
        logic [NB_LOOPS*CNT_WIDTH-1:0] idx;
        logic                          done;
    } entry_t;

    uloop_sched_state_t state_q, state_d;

    entry_t                      push_data, head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full, fifo_empty;
    logic                        rst, push, push_ok, pop, flush;
    logic                        abort_go, abort_q, err_q;

    assign rst       = rst_i || clear_i;
    assign push      = (state_q == RUN) && uloop_valid_i;
    assign pop       = !fifo_empty && offs_ready_i;
    assign push_ok   = push && (!fifo_full || pop);
    assign flush     = (state_q == PRIME) || abort_go;
    assign push_data = '{offs: uloop_offs_i, idx: uloop_idx_i, done: uloop_done_i};

    hwpe_ctrl_uloop_sched_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_go;
            if (state_q == PRIME)
                err_q <= 1'b0;
            else if (push && fifo_full && !pop && !abort_go)
                err_q <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        abort_go = 1'b0;
        unique case (state_q)
            IDLE:    if (start_i) state_d = PRIME;
            PRIME:   state_d = RUN;
            RUN:     if (push_ok && uloop_done_i) state_d = DRAIN;
            DRAIN:   if (pop && head.done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q inside {PRIME, RUN, DRAIN})) begin
            state_d  = IDLE;
            abort_go = 1'b1;
        end
    end

    // Enable only while two slots remain, so a valid already in flight always fits.
    assign uloop_enable_o = (state_q == RUN) && (32'(fifo_count) + 32'd2 <= 32'(FIFO_DEPTH));
    assign uloop_clear_o  = (state_q == PRIME) || abort_q;
    assign busy_o         = state_q inside {PRIME, RUN, DRAIN};
    assign evt_done_o     = (state_q == DONE);
    assign err_o          = err_q;
    assign offs_valid_o   = !fifo_empty;
    assign offs_o         = fifo_empty ? '0 : head.offs;
    assign idx_o          = fifo_empty ? '0 : head.idx;
    assign last_o         = !fifo_empty && head.done;

`ifdef HWPE_ULOOP_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst || perf_clr_i)
            stall_cnt_q <= '0;
        else if ((state_q == RUN) && fifo_empty && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
